// File: rtl/cadr_clock_parts_if.sv
// Bus bundle for the CADR clock-section primitives: 74S151 mux and TD100/TD25/TD50 taps.
// TD50 signals exist only when CADR_TD50_EN is defined.
`timescale 1ns/1ps
interface cadr_clock_parts_if;
  logic [7:0] mux_i;
  logic [2:0] mux_sel;
  logic       mux_ce_n;
  logic       mux_q;
  logic       mux_q_n;
  logic       td100_in;
  logic [4:0] td100_o;
  logic       td25_in;
  logic [4:0] td25_o;
`ifdef CADR_TD50_EN
  logic       td50_in;
  logic [4:0] td50_o;

  modport master (
    output mux_i, mux_sel, mux_ce_n, td100_in, td25_in, td50_in,
    input  mux_q, mux_q_n, td100_o, td25_o, td50_o
  );
  modport slave (
    input  mux_i, mux_sel, mux_ce_n, td100_in, td25_in, td50_in,
    output mux_q, mux_q_n, td100_o, td25_o, td50_o
  );
`else
  modport master (
    output mux_i, mux_sel, mux_ce_n, td100_in, td25_in,
    input  mux_q, mux_q_n, td100_o, td25_o
  );
  modport slave (
    input  mux_i, mux_sel, mux_ce_n, td100_in, td25_in,
    output mux_q, mux_q_n, td100_o, td25_o
  );
`endif
endinterface

// File: rtl/cadr_clock_parts.sv
// CADR clock-section primitives: combinational 74S151 8:1 mux plus tick-quantized tapped
// delay lines TD100 and TD25; the TD50 line is compiled in only with CADR_TD50_EN.
`timescale 1ns/1ps

// Five-tap shift-register delay line; tap k sits at (k+1)*TAP_NS.
module cadr_tdline #(
  parameter int unsigned TAP_NS  = 20,
  parameter int unsigned TICK_NS = 5,
  parameter logic        INIT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_i,
  output logic [4:0] taps_o
);
  localparam int unsigned STEP  = (TAP_NS >= TICK_NS) ? (TAP_NS / TICK_NS) : 1;
  localparam int unsigned DEPTH = 5 * STEP;

  if ((TAP_NS < TICK_NS) || ((TAP_NS % TICK_NS) != 0)) begin : g_bad_tick
    $error("cadr_tdline: tap spacing %0d ns is not a multiple of tick %0d ns", TAP_NS, TICK_NS);
  end

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], line_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= {DEPTH{INIT}};
    else       stage_q <= stage_d;
  end

  for (genvar k = 0; k < 5; k++) begin : g_tap
    assign taps_o[k] = stage_q[(k + 1) * STEP - 1];
  end
endmodule

module cadr_clock_parts #(
  parameter int unsigned TICK_NS = 5,
  parameter logic        INIT    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  cadr_clock_parts_if.slave  bus
);
  logic mux_q_c;

  // Disabled 74S151 drives Y low / W high regardless of select.
  always_comb begin
    mux_q_c = 1'b0;
    if (!bus.mux_ce_n) mux_q_c = bus.mux_i[bus.mux_sel];
  end

  assign bus.mux_q   = mux_q_c;
  assign bus.mux_q_n = ~mux_q_c;

  cadr_tdline #(.TAP_NS(20), .TICK_NS(TICK_NS), .INIT(INIT)) u_td100 (
    .clk    (clk),
    .reset  (reset),
    .line_i (bus.td100_in),
    .taps_o (bus.td100_o)
  );

  cadr_tdline #(.TAP_NS(5), .TICK_NS(TICK_NS), .INIT(INIT)) u_td25 (
    .clk    (clk),
    .reset  (reset),
    .line_i (bus.td25_in),
    .taps_o (bus.td25_o)
  );

`ifdef CADR_TD50_EN
  cadr_tdline #(.TAP_NS(10), .TICK_NS(TICK_NS), .INIT(INIT)) u_td50 (
    .clk    (clk),
    .reset  (reset),
    .line_i (bus.td50_in),
    .taps_o (bus.td50_o)
  );
`endif
endmodule

// File: tb/tb_cadr_clock_parts.sv
// Directed self-checking bench for cadr_clock_parts (mux, TD25, TD100, ring oscillator, TD50).
`timescale 1ns/1ps
module tb_cadr_clock_parts;
  logic clk;
  logic reset;
  logic ring_en;
  logic td100_drv;
  int   errors;
  int   checks;

  cadr_clock_parts_if bus ();

  cadr_clock_parts #(.TICK_NS(5), .INIT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.td100_in = ring_en ? ~bus.td100_o[4] : td100_drv;

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    ring_en   = 1'b0;
    td100_drv = 1'b0;
    bus.td25_in = 1'b0;
`ifdef CADR_TD50_EN
    bus.td50_in = 1'b0;
`endif
    bus.mux_i    = 8'h00;
    bus.mux_sel  = 3'd0;
    bus.mux_ce_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.td100_o !== 5'b11111) begin
      errors++; $display("FAIL reset_td100: got %b want 11111", bus.td100_o);
    end
    checks++;
    if (bus.td25_o !== 5'b11111) begin
      errors++; $display("FAIL reset_td25: got %b want 11111", bus.td25_o);
    end
`ifdef CADR_TD50_EN
    checks++;
    if (bus.td50_o !== 5'b11111) begin
      errors++; $display("FAIL reset_td50: got %b want 11111", bus.td50_o);
    end
`endif
    bus.mux_ce_n = 1'b0;
    bus.mux_sel  = 3'd3;
    bus.mux_i    = 8'h08;
    #1;
    checks++;
    if (bus.mux_q !== 1'b1 || bus.mux_q_n !== 1'b0) begin
      errors++; $display("FAIL reset_mux: got q=%b qn=%b want q=1 qn=0", bus.mux_q, bus.mux_q_n);
    end
  endtask

  task automatic test_mux;
    bit exp_q [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.mux_i    = 8'b1010_0110;
    bus.mux_ce_n = 1'b0;
    for (int s = 0; s < 8; s++) begin
      bus.mux_sel = 3'(s);
      #1;
      checks++;
      if (bus.mux_q !== exp_q[s] || bus.mux_q_n !== ~exp_q[s]) begin
        errors++;
        $display("FAIL mux_sel%0d: got q=%b qn=%b want q=%b qn=%b",
                 s, bus.mux_q, bus.mux_q_n, exp_q[s], ~exp_q[s]);
      end
    end
    bus.mux_ce_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.mux_sel = 3'(s);
      #1;
      checks++;
      if (bus.mux_q !== 1'b0 || bus.mux_q_n !== 1'b1) begin
        errors++;
        $display("FAIL mux_dis_sel%0d: got q=%b qn=%b want q=0 qn=1", s, bus.mux_q, bus.mux_q_n);
      end
    end
  endtask

  task automatic test_td25_step;
    logic [4:0] exp_t;
    bus.td25_in = 1'b1;
    do_reset();
    repeat (2) tick();
    checks++;
    if (bus.td25_o !== 5'b11111) begin
      errors++; $display("FAIL td25_idle: got %b want 11111", bus.td25_o);
    end
    bus.td25_in = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      for (int k = 0; k < 5; k++) exp_t[k] = (n >= k + 1) ? 1'b0 : 1'b1;
      checks++;
      if (bus.td25_o !== exp_t) begin
        errors++; $display("FAIL td25_step_edge%0d: got %b want %b", n, bus.td25_o, exp_t);
      end
    end
  endtask

  task automatic test_td100_pulse;
    logic [4:0] exp_t;
    int m;
    td100_drv = 1'b1;
    do_reset();
    td100_drv = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (n == 4) td100_drv = 1'b1;
      // tap k shows the sample taken 4*(k+1)-1 edges before edge n; edges 1..4 were low
      for (int k = 0; k < 5; k++) begin
        m = n - 4 * (k + 1) + 1;
        exp_t[k] = (m >= 1 && m <= 4) ? 1'b0 : 1'b1;
      end
      checks++;
      if (bus.td100_o !== exp_t) begin
        errors++; $display("FAIL td100_pulse_edge%0d: got %b want %b", n, bus.td100_o, exp_t);
      end
    end
  endtask

  task automatic test_ring;
    int low_cnt;
    low_cnt = 0;
    ring_en = 1'b1;
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n >= 20 && n <= 59 && bus.td100_o[4] === 1'b0) low_cnt++;
      if (n == 19 || n == 20 || n == 39 || n == 40 || n == 59 || n == 60) begin
        checks++;
        if (bus.td100_o[4] !== (((n / 20) % 2) == 0 ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL ring_edge%0d: got %b want %b", n, bus.td100_o[4],
                   (((n / 20) % 2) == 0 ? 1'b1 : 1'b0));
        end
      end
    end
    checks++;
    if (low_cnt != 20) begin
      errors++; $display("FAIL ring_duty: low ticks %0d want 20", low_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.td100_o !== 5'b11111) begin
      errors++; $display("FAIL ring_async_reset: got %b want 11111", bus.td100_o);
    end
    ring_en = 1'b0;
    td100_drv = 1'b1;
    tick();
  endtask

`ifdef CADR_TD50_EN
  task automatic test_td50;
    logic [4:0] exp_t;
    bus.td50_in = 1'b1;
    do_reset();
    bus.td50_in = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) bus.td50_in = 1'b1;
      for (int k = 0; k < 5; k++) exp_t[k] = (n == 2 * (k + 1)) ? 1'b0 : 1'b1;
      checks++;
      if (bus.td50_o !== exp_t) begin
        errors++; $display("FAIL td50_pulse_edge%0d: got %b want %b", n, bus.td50_o, exp_t);
      end
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mux();
    test_td25_step();
    test_td100_pulse();
    test_ring();
`ifdef CADR_TD50_EN
    test_td50();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
